// File: rtl/if_fetch_pkg.sv
// Shared constants, types and helpers for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic                   RstEnable   = 1'b0;
  localparam logic                   JumpEnable  = 1'b1;
  localparam logic                   ImemAckTrue = 1'b1;
  localparam logic [InstBus-1:0]     ZeroWord    = 32'h0000_0000;

  typedef logic [InstAddrBus-1:0] addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

  // Word-addressed PC step; wraps from all-ones back to zero.
  function automatic addr_t pc_inc(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Bundles the instruction-memory port and the decode-facing signals of the fetch stage.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic  stall_i;
  logic  branch_flag_i;
  addr_t branch_target_addr_i;
  logic  imem_req_o;
  addr_t imem_addr_o;
  logic  imem_ack_i;
  inst_t imem_rdata_i;
  addr_t id_pc_o;
  inst_t id_inst_o;
  logic  id_valid_o;

  modport master (
    input  stall_i, branch_flag_i, branch_target_addr_i, imem_ack_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, id_pc_o, id_inst_o, id_valid_o
  );

  modport slave (
    output stall_i, branch_flag_i, branch_target_addr_i, imem_ack_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, id_pc_o, id_inst_o, id_valid_o
  );

endinterface

// File: rtl/if_fetch_buf.sv
// DEPTH-entry {pc,inst} FIFO between the memory port and decode.
// The head is registered so it holds its last value while the buffer is empty.
module fetch_buf
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  addr_t                    i_push_pc,
  input  inst_t                    i_push_inst,
  input  logic                     i_pop,
  input  logic                     i_flush_after_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_valid,
  output addr_t                    o_head_pc,
  output inst_t                    o_head_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_rd;
  logic [CW-1:0]  r_count;
  logic           r_valid;
  addr_t          r_head_pc;
  inst_t          r_head_inst;

  logic [CW-1:0]  w_left;
  logic [CW-1:0]  w_kept;
  logic [CW-1:0]  w_count_nxt;
  logic [PW-1:0]  w_rd_nxt;
  logic [PW-1:0]  w_wr;
  fetch_entry_t   w_head_nxt;

  // Next occupancy: pop first, then a flush keeps only the new head, then the push lands behind it.
  always_comb begin
    w_left      = r_count - CW'(i_pop);
    w_kept      = (i_flush_after_head && (w_left > CW'(1))) ? CW'(1) : w_left;
    w_count_nxt = w_kept + CW'(i_push);
    w_rd_nxt    = r_rd + PW'(i_pop);
    w_wr        = w_rd_nxt + w_kept[PW-1:0];
    w_head_nxt  = (w_kept != '0) ? r_mem[w_rd_nxt] : fetch_entry_t'({i_push_pc, i_push_inst});
  end

  // Storage array; entries carry data only, so no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr] <= fetch_entry_t'({i_push_pc, i_push_inst});
  end

  // Pointers, occupancy and registered head presented to decode.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_rd        <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_head_pc   <= ZeroWord;
      r_head_inst <= ZeroWord;
    end else begin
      r_rd    <= w_rd_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_head_pc   <= w_head_nxt.pc;
        r_head_inst <= w_head_nxt.inst;
      end
    end
  end

  assign o_count     = r_count;
  assign o_valid     = r_valid;
  assign o_head_pc   = r_head_pc;
  assign o_head_inst = r_head_inst;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, single-outstanding request port,
// fetch buffer towards decode, and delay-slot branch redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000,
  parameter int    DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_CNT  = CW'(2);

  logic          r_req;
  addr_t         r_addr;
  addr_t         r_fetch_pc;
  logic          r_drop;
  logic          r_pend;
  addr_t         r_target;

  logic [CW-1:0] w_count;
  logic          w_id_valid;
  addr_t         w_id_pc;
  inst_t         w_id_inst;
  logic          w_accept;
  logic          w_branch;
  logic          w_ack;
  logic          w_ds_buffered;
  logic          w_case_a;
  logic          w_case_b;
  logic          w_ack_beyond;
  logic          w_push;
  logic          w_issue;

  // Classify this cycle: accept/branch, whether the delay slot is already issued, and what the ack means.
  always_comb begin
    w_accept      = w_id_valid & ~bus.stall_i;
    w_branch      = w_accept & (bus.branch_flag_i == JumpEnable);
    w_ack         = r_req & (bus.imem_ack_i == ImemAckTrue);
    // With the slot already in the buffer, anything in flight lies past it.
    w_ds_buffered = (w_count >= TWO_CNT);
    w_case_a      = w_branch & (w_ds_buffered | r_req);
    w_case_b      = w_branch & ~(w_ds_buffered | r_req);
    w_ack_beyond  = w_ack & w_branch & w_ds_buffered;
    w_push        = w_ack & ~r_drop & ~w_ack_beyond;
    // Only one outstanding request; none starts on a redirect cycle.
    w_issue       = ~r_req & ~w_branch & (w_count < FULL_CNT);
  end

  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk                (clk),
    .rst                (rst),
    .i_push             (w_push),
    .i_push_pc          (r_addr),
    .i_push_inst        (bus.imem_rdata_i),
    .i_pop              (w_accept),
    .i_flush_after_head (w_case_a),
    .o_count            (w_count),
    .o_valid            (w_id_valid),
    .o_head_pc          (w_id_pc),
    .o_head_inst        (w_id_inst)
  );

  // Request FSM (single FETCH state) with drop/redirect flags; fetch_pc is the next address to issue.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
      r_pend     <= 1'b0;
      r_target   <= ZeroWord;
    end else begin
      if (w_ack) begin
        r_req <= 1'b0;
      end else if (w_issue) begin
        r_req  <= 1'b1;
        r_addr <= r_fetch_pc;
      end

      if (w_ack) r_drop <= 1'b0;
      if (w_case_a && r_req && !w_ack && w_ds_buffered) r_drop <= 1'b1;

      if (w_case_b) begin
        r_pend   <= 1'b1;
        r_target <= bus.branch_target_addr_i;
      end else if (r_pend && w_ack) begin
        r_pend <= 1'b0;
      end

      if (w_case_a) begin
        r_fetch_pc <= bus.branch_target_addr_i;
      end else if (w_issue) begin
        r_fetch_pc <= r_pend ? r_target : pc_inc(r_fetch_pc);
      end
    end
  end

  assign bus.imem_req_o  = r_req;
  assign bus.imem_addr_o = r_addr;
  assign bus.id_pc_o     = w_id_pc;
  assign bus.id_inst_o   = w_id_inst;
  assign bus.id_valid_o  = w_id_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch: a program-order model of the
// decode stream (sequential PCs, one delay slot, then the target).
`timescale 1ns/1ps
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam addr_t RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_fetch_if bus();

  if_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks   = 0;
  int    errors   = 0;
  int    accepts  = 0;
  addr_t exp_q[$];
  addr_t addr_log[$];

  int    stall_pct = 0;
  int    br_pct    = 0;
  int    ack_max   = 0;
  bit    fixed_lat = 1'b1;

  function automatic inst_t mem_word(input addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Instruction memory: random latency, optional same-cycle ack, address stability check.
  initial begin
    int    lat;
    bit    have_req;
    addr_t req_addr;
    lat = 0; have_req = 1'b0; req_addr = '0;
    bus.imem_ack_i   = 1'b0;
    bus.imem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.imem_ack_i = 1'b0;
        have_req = 1'b0;
      end else if (bus.imem_req_o) begin
        if (!have_req) begin
          have_req = 1'b1;
          req_addr = bus.imem_addr_o;
          lat = fixed_lat ? 1 : int'($urandom_range(0, ack_max));
        end else begin
          check("addr_stable", bus.imem_addr_o, req_addr);
        end
        if (lat == 0) begin
          bus.imem_ack_i   = 1'b1;
          bus.imem_rdata_i = mem_word(req_addr);
          addr_log.push_back(req_addr);
          have_req = 1'b0;
        end else begin
          bus.imem_ack_i = 1'b0;
          lat--;
        end
      end else begin
        bus.imem_ack_i = 1'b0;
        have_req = 1'b0;
      end
    end
  end

  // Decode-side driver: stall and branch stimulus; a taken branch queues its delay slot and target.
  initial begin
    bit    acc;
    addr_t tgt;
    bus.stall_i              = 1'b0;
    bus.branch_flag_i        = 1'b0;
    bus.branch_target_addr_i = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.stall_i       = 1'b0;
        bus.branch_flag_i = 1'b0;
      end else begin
        bus.stall_i = (int'($urandom_range(0, 99)) < stall_pct);
        acc = bus.id_valid_o && !bus.stall_i;
        tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : addr_t'($urandom_range(0, 1023));
        bus.branch_target_addr_i = tgt;
        if (acc && exp_q.size() == 1 && int'($urandom_range(0, 99)) < br_pct) begin
          bus.branch_flag_i = 1'b1;
          exp_q.push_back(pc_inc(exp_q[0]));
          exp_q.push_back(tgt);
        end else if (!acc) begin
          bus.branch_flag_i = 1'($urandom_range(0, 1));
        end else begin
          bus.branch_flag_i = 1'b0;
        end
      end
    end
  end

  // Monitor: every accepted instruction is popped from the scoreboard and compared.
  initial begin
    addr_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && bus.id_valid_o && !bus.stall_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got pc %h expected none", bus.id_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", bus.id_pc_o, e);
          check("id_inst", bus.id_inst_o, mem_word(e));
          if (exp_q.size() == 0) exp_q.push_back(pc_inc(e));
          accepts++;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(bus.imem_req_o), 32'd0);
    check({tag, "_addr"},  bus.imem_addr_o,     RST_PC);
    check({tag, "_valid"}, 32'(bus.id_valid_o), 32'd0);
    check({tag, "_pc"},    bus.id_pc_o,         32'd0);
    check({tag, "_inst"},  bus.id_inst_o,       32'd0);
  endtask

  task automatic release_reset();
    exp_q.delete();
    exp_q.push_back(RST_PC);
    addr_log.delete();
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("first_req",      32'(bus.imem_req_o), 32'd1);
    check("first_req_addr", bus.imem_addr_o,     RST_PC);
  endtask

  task automatic run_phase(input string name, input int cycles, input int min_acc);
    int a0;
    a0 = accepts;
    repeat (cycles) @(negedge clk);
    check({name, "_progress"}, 32'(accepts - a0 >= min_acc), 32'd1);
  endtask

  initial begin
    bit found;

    repeat (3) @(negedge clk);
    #3 check_reset_outputs("por");
    release_reset();

    // Sequential fetch, ack one cycle after each request, no stall.
    stall_pct = 0; br_pct = 0; fixed_lat = 1'b1;
    run_phase("seq", 20, 4);
    check("seq_log_len", 32'(addr_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", (i < addr_log.size()) ? addr_log[i] : 32'hDEAD_BEEF, addr_t'(i));
    end

    // Long stall with a fast memory: the buffer fills and requests stop.
    fixed_lat = 1'b0; ack_max = 1; stall_pct = 100;
    repeat (10) @(negedge clk);
    #3;
    check("full_req_low",  32'(bus.imem_req_o), 32'd0);
    check("full_valid",    32'(bus.id_valid_o), 32'd1);
    stall_pct = 0;
    run_phase("drain", 20, 4);

    // Random stalls, latencies and branches.
    stall_pct = 60; ack_max = 2;
    run_phase("stall", 300, 20);
    stall_pct = 30; ack_max = 3; br_pct = 40;
    run_phase("branch", 3000, 200);

    // Reset while a request is outstanding and unacknowledged.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #3;
      if (bus.imem_req_o && !bus.imem_ack_i) found = 1'b1;
    end
    check("mid_req_found", 32'(found), 32'd1);
    rst = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    release_reset();
    run_phase("post_rst", 1000, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
